// File: rtl/aes_host_issuer_pkg.sv
// Shared system definitions for the AES host issuer: packet type, mode encodings
// and assembler states. Optional statistics port is enabled by AES_ISSUER_STATS_EN.
package aes_host_issuer_pkg;

    localparam logic [1:0] MODE_KEY  = 2'd0;
    localparam logic [1:0] MODE_ENC  = 2'd1;
    localparam logic [1:0] MODE_DEC  = 2'd2;
    localparam logic [1:0] MODE_RSVD = 2'd3;

    localparam int BLOCK_W = 128;
    localparam int FIFO_W  = 130;

    typedef struct packed {
        logic         valid;
        logic [1:0]   mode;
        logic [127:0] data;
    } in_packet_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_STALL
    } asm_state_t;

endpackage

// File: rtl/aes_host_issuer_block.sv
// Block FIFO used by the issuer to queue assembled packets for the engine.
// Circular buffer of DEPTH entries; pointers wrap naturally because DEPTH is a power of two.
module aes_block_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 130
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign push_ok   = push && !full;
    assign pop_ok    = pop && !empty;
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/aes_host_issuer.sv
// Assembles four 32-bit host words into a 128-bit AES packet and queues it for the engine.
// Define AES_ISSUER_STATS_EN to add the saturating issued_cnt pop counter.
module aes_host_issuer
    import aes_host_issuer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   host_valid,
    output logic                   host_ready,
    input  logic [31:0]            host_data,
    input  logic [1:0]             host_mode,
    output in_packet_t             pkt_out,
    input  logic                   load_data,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   mode_err
`ifdef AES_ISSUER_STATS_EN
    ,
    output logic [15:0]            issued_cnt
`endif
);

    asm_state_t         state;
    asm_state_t         state_next;
    logic [1:0]         word_cnt;
    logic [1:0]         mode_q;
    logic [95:0]        buf_q;
    logic               ready_en;
    logic               handshake;
    logic               last_word;
    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_empty;
    logic               fifo_full;
    logic [FIFO_W-1:0]  fifo_head;
    logic [FIFO_W-1:0]  push_data;

    assign handshake = host_valid && host_ready;
    assign last_word = (state == ST_STALL) || (state == ST_COLLECT && word_cnt == 2'd3);
    assign push_data = {mode_q, buf_q, host_data};
    assign fifo_pop  = load_data && !fifo_empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (handshake) begin
                    state_next = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (word_cnt == 2'd3 && fifo_full) begin
                    state_next = ST_STALL;
                end else if (handshake && word_cnt == 2'd3) begin
                    state_next = ST_IDLE;
                end
            end
            ST_STALL: begin
                if (handshake) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // host_ready depends only on flops so the engine's load_data never reaches the host path.
    always_comb begin
        host_ready = 1'b0;
        if (ready_en) begin
            case (state)
                ST_IDLE:    host_ready = 1'b1;
                ST_COLLECT: host_ready = !(word_cnt == 2'd3 && fifo_full);
                ST_STALL:   host_ready = !fifo_full;
                default:    host_ready = 1'b0;
            endcase
        end
        fifo_push = host_valid && host_ready && last_word && (mode_q != MODE_RSVD);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ready_en <= 1'b0;
            word_cnt <= 2'd0;
            mode_q   <= MODE_KEY;
            buf_q    <= '0;
            mode_err <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (handshake) begin
                word_cnt <= last_word ? 2'd0 : word_cnt + 2'd1;
                case (word_cnt)
                    2'd0: begin
                        mode_q        <= host_mode;
                        buf_q[95:64]  <= host_data;
                        if (host_mode == MODE_RSVD) begin
                            mode_err <= 1'b1;
                        end
                    end
                    2'd1:    buf_q[63:32] <= host_data;
                    2'd2:    buf_q[31:0]  <= host_data;
                    default: buf_q        <= buf_q;
                endcase
            end
        end
    end

    aes_block_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FIFO_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (push_data),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // Stale RAM contents are masked so an empty queue always presents an all-zero packet.
    always_comb begin
        pkt_out = '0;
        if (!fifo_empty) begin
            pkt_out.valid = 1'b1;
            pkt_out.mode  = fifo_head[129:128];
            pkt_out.data  = fifo_head[127:0];
        end
    end

`ifdef AES_ISSUER_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            issued_cnt <= 16'd0;
        end else if (fifo_pop && issued_cnt != 16'hFFFF) begin
            issued_cnt <= issued_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: doc/aes_host_issuer.md
AES_HOST_ISSUER -- requirements
Module: aes_host_issuer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning block FIFO entries; legal values are 2, 4 and 8.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port host_valid  input  1  host word present.
REQ-005 SHALL have port host_ready  output  1  issuer accepts host word this cycle.
REQ-006 SHALL have port host_data  input  32  block word.
REQ-007 SHALL have port host_mode  input  2  packet op; 0 = key load, 1 = encrypt, 2 = decrypt, 3 = reserved.
REQ-008 SHALL have port pkt_out  output  in_packet_t  packet to engine; uses fields valid, mode[1:0], data[127:0].
REQ-009 SHALL have port load_data  input  1  engine consumes pkt_out this cycle when pkt_out.valid is high.
REQ-010 SHALL have port fifo_count  output  $clog2(DEPTH)+1  blocks buffered.
REQ-011 SHALL have port mode_err  output  1  sticky flag for reserved mode seen.

Function
REQ-012 SHALL complete a host handshake on any cycle where host_valid and host_ready are both high.
REQ-013 SHALL run an assembler FSM with states IDLE, COLLECT and STALL.
- IDLE: word_cnt = 0.
- COLLECT: word_cnt = 1..3.
- STALL: 4th word pending while FIFO is full.
REQ-014 SHALL capture host_mode on word 0 only; host_mode on words 1..3 is ignored.
REQ-015 SHALL map words big-endian: word0 to data[127:96], word3 to data[31:0].
REQ-016 SHALL hold host_ready high in IDLE and COLLECT, except on the word_cnt = 3 cycle when the FIFO is full.
- In that case host_ready is low and the FSM enters STALL.
REQ-017 SHALL drive host_ready from registered state only, never combinationally from load_data.
- A full FIFO blocks a push even when a pop occurs in the same cycle.
REQ-018 SHALL push the assembled block into the FIFO in the same cycle as the 4th handshake and return to IDLE.
REQ-019 SHALL, in STALL, raise host_ready once fifo_count < DEPTH, then accept the 4th word as in REQ-018.
REQ-020 SHALL drive pkt_out.valid = FIFO not empty, with pkt_out.mode and pkt_out.data taken from the FIFO head.
- All other in_packet_t fields are 0.
REQ-021 SHALL pop the FIFO head on a cycle where pkt_out.valid and load_data are both high.
- pkt_out holds stable while load_data is low.
REQ-022 SHALL give latency from the 4th handshake to pkt_out.valid of exactly 1 cycle when the FIFO was empty.
REQ-023 SHALL, on a simultaneous push and pop with the FIFO neither full nor empty, leave fifo_count unchanged and preserve order.
REQ-024 SHALL wrap read and write pointers modulo DEPTH.
REQ-025 SHALL, on a reserved mode on word 0, drop the entire block (4 words accepted, no push) and set mode_err until reset.

Reset
REQ-026 SHALL apply rst_n low on a clock edge as follows:
- FSM to IDLE, word_cnt = 0, FIFO empty, fifo_count = 0, mode_err = 0, pkt_out = all zeros.
- host_ready = 0 during reset, 1 on the first cycle after.
REQ-027 SHALL discard a partial block and all buffered blocks on reset mid-operation; nothing is issued afterwards.

Configuration
REQ-028 SHALL, with macro AES_ISSUER_STATS_EN defined, add port issued_cnt  output  16.
- issued_cnt counts pops, saturates at 16'hFFFF and resets to 0.
- Without the macro, the port and counter are absent and behaviour is otherwise identical.

Structure
REQ-029 SHALL place the mode encodings (MODE_KEY, MODE_ENC, MODE_DEC) and in_packet_t in the shared sysdef package; no local redefinition is allowed.
REQ-030 SHALL implement the buffer as one sub-module, aes_block_fifo, parameterised by DEPTH and width 130.

Verification
REQ-031 SHALL cover single block: words 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF, mode 1, load_data high.
- Response: pkt_out.valid high 1 cycle after word 4, data = 0x00112233_44556677_8899AABB_CCDDEEFF, mode = 1.
REQ-032 SHALL cover backpressure: DEPTH = 4, load_data low, 5 blocks sent.
- Response: fifo_count = 4 and host_ready low on the 20th word.
- One load_data pulse, then the 5th block is accepted and fifo_count returns to 4.
REQ-033 SHALL cover ordering: 8 blocks in with load_data toggling every cycle.
- Response: output order and data match input, no loss.
REQ-034 SHALL cover mode handling: word 0 mode 3 -> block dropped and mode_err = 1; host_mode changed on word 2 -> ignored.
REQ-035 SHALL cover reset after 2 of 4 words with 1 block buffered.
- Response: fifo_count = 0 and pkt_out.valid = 0 after reset; the next 4 words form a fresh block.
REQ-036 SHALL cover, with AES_ISSUER_STATS_EN defined, 3 pops -> issued_cnt = 3.
